// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 prefetch unit: icode values, the
// "no register" marker and the fetch FSM state encoding.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    // IDLE: no request; REQ: request held until accepted;
    // WAIT: one request outstanding; DROP: outstanding response is stale.
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2,
        FS_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/y86_ilen.sv
// Decodes the head of the byte queue: instruction length, split fields,
// register-byte presence and validity of the icode.
module y86_ilen
    import y86_pkg::*;
(
    input  logic [79:0] head,        // byte i at bits 8i+7:8i
    output logic [3:0]  len,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,          // raw high nibble of byte 1
    output logic [3:0]  rb,          // raw low nibble of byte 1
    output logic [63:0] valc,
    output logic        instr_valid,
    output logic        has_regids
);

    // Length and constant placement depend only on the icode nibble.
    always_comb begin
        icode       = head[7:4];
        ifun        = head[3:0];
        ra          = head[15:12];
        rb          = head[11:8];
        len         = 4'd1;
        valc        = 64'h0;
        has_regids  = 1'b0;
        instr_valid = 1'b1;
        case (icode)
            IHALT, INOP, IRET: len = 4'd1;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
                len        = 4'd2;
                has_regids = 1'b1;
            end
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                len        = 4'd10;
                has_regids = 1'b1;
                valc       = head[79:16];
            end
            IJXX, ICALL: begin
                len  = 4'd9;
                valc = head[71:8];
            end
            default: instr_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_prefetch.sv
// Y86-64 prefetch unit: streams aligned 8-byte words into a byte queue and
// presents one split instruction per valid/ready handshake.
// Handshakes: imem_req is held until imem_ready (accept); ins_valid/ins_ready
// transfer when both are high on a clock edge, and outputs stay stable while
// ins_valid is high and ins_ready is low (redirect excepted).
module y86_prefetch
    import y86_pkg::*;
#(
    parameter int          BUF_BYTES = 16,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [63:0] imem_rdata,
    input  logic        imem_error,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [63:0] PC,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_err_out,
    output logic [1:0]  dbg_state,
    output logic [$clog2(BUF_BYTES+1)-1:0] dbg_count
);

    localparam int CW = $clog2(BUF_BYTES + 1);

    fetch_state_e  state_q, state_d;
    logic [7:0]    buf_q [BUF_BYTES];
    logic [7:0]    buf_d [BUF_BYTES];
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   pc_q, pc_d;
    logic [63:0]   faddr_q, faddr_d;
    logic [2:0]    skip_q, skip_d;
    logic          halted_q, halted_d;
    logic          errored_q, errored_d;
    logic          err_done_q, err_done_d;

    logic [79:0]   head;
    logic [3:0]    h_len, h_icode, h_ifun, h_ra, h_rb;
    logic [63:0]   h_valc;
    logic          h_iv, h_has_regids;
    logic          err_slot, xfer, append;
    logic [CW-1:0] consumed, base, free_cnt;
    logic [3:0]    app_n;

    // Head window: the first ten queued bytes feed the length decoder.
    always_comb begin
        for (int i = 0; i < 10; i++) head[8*i +: 8] = buf_q[i];
    end

    y86_ilen u_ilen (
        .head        (head),
        .len         (h_len),
        .icode       (h_icode),
        .ifun        (h_ifun),
        .ra          (h_ra),
        .rb          (h_rb),
        .valc        (h_valc),
        .instr_valid (h_iv),
        .has_regids  (h_has_regids)
    );

    assign imem_req  = (state_q == FS_REQ);
    assign imem_addr = faddr_q;
    assign dbg_state = state_q;
    assign dbg_count = count_q;
    assign PC        = pc_q;

    // Presentation: either a complete head instruction or the one error slot.
    always_comb begin
        err_slot     = errored_q && !err_done_q && (count_q < CW'(h_len));
        ins_valid    = !redirect && (err_slot || (count_q >= CW'(h_len)));
        xfer         = ins_valid && ins_ready;
        icode        = 4'h0;
        ifun         = 4'h0;
        rA           = RNONE;
        rB           = RNONE;
        valC         = 64'h0;
        valP         = 64'h0;
        instr_valid  = 1'b0;
        imem_err_out = 1'b0;
        if (ins_valid && err_slot) begin
            imem_err_out = 1'b1;
            instr_valid  = 1'b1;
            valP         = pc_q;
        end else if (ins_valid) begin
            icode       = h_icode;
            ifun        = h_ifun;
            rA          = h_has_regids ? h_ra : RNONE;
            rB          = h_has_regids ? h_rb : RNONE;
            valC        = h_valc;
            valP        = pc_q + 64'(h_len);
            instr_valid = h_iv;
        end
    end

    // Next state: consume at the head, append at the tail, fetch FSM, redirect.
    always_comb begin
        consumed   = (xfer && !err_slot) ? CW'(h_len) : '0;
        base       = count_q - consumed;
        free_cnt   = CW'(BUF_BYTES) - count_q;
        app_n      = 4'd8 - {1'b0, skip_q};
        append     = (state_q == FS_WAIT) && imem_rvalid && !imem_error;
        state_d    = state_q;
        count_d    = base;
        pc_d       = (xfer && !err_slot) ? pc_q + 64'(h_len) : pc_q;
        faddr_d    = faddr_q;
        skip_d     = skip_q;
        halted_d   = halted_q || (xfer && !err_slot && (h_icode == IHALT));
        errored_d  = errored_q;
        err_done_d = err_done_q || (xfer && err_slot);

        for (int i = 0; i < BUF_BYTES; i++) begin
            if (i + int'(consumed) < BUF_BYTES) buf_d[i] = buf_q[i + int'(consumed)];
            else                                buf_d[i] = 8'h00;
        end

        // Response bytes below the entry offset of the first word are skipped.
        if (append) begin
            for (int i = 0; i < BUF_BYTES; i++) begin
                if ((i >= int'(base)) && (i < int'(base) + int'(app_n)))
                    buf_d[i] = imem_rdata[8*(i - int'(base) + int'(skip_q)) +: 8];
            end
            count_d = base + CW'(app_n);
        end

        case (state_q)
            FS_IDLE: if ((free_cnt >= CW'(8)) && !halted_d && !errored_q) state_d = FS_REQ;
            FS_REQ:  if (imem_ready) state_d = FS_WAIT;
            FS_WAIT: if (imem_rvalid) begin
                state_d = FS_IDLE;
                if (imem_error) begin
                    errored_d = 1'b1;
                end else begin
                    faddr_d = faddr_q + 64'd8;
                    skip_d  = 3'd0;
                end
            end
            FS_DROP: if (imem_rvalid) state_d = FS_IDLE;
            default: state_d = FS_IDLE;
        endcase

        // A redirect overrides everything above; an in-flight word becomes stale.
        if (redirect) begin
            count_d    = '0;
            pc_d       = redirect_pc;
            faddr_d    = {redirect_pc[63:3], 3'b000};
            skip_d     = redirect_pc[2:0];
            halted_d   = 1'b0;
            errored_d  = 1'b0;
            err_done_d = 1'b0;
            case (state_q)
                FS_WAIT: state_d = imem_rvalid ? FS_IDLE : FS_DROP;
                FS_DROP: state_d = imem_rvalid ? FS_IDLE : FS_DROP;
                default: state_d = FS_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FS_IDLE;
            count_q    <= '0;
            pc_q       <= RESET_PC;
            faddr_q    <= {RESET_PC[63:3], 3'b000};
            skip_q     <= RESET_PC[2:0];
            halted_q   <= 1'b0;
            errored_q  <= 1'b0;
            err_done_q <= 1'b0;
            for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            faddr_q    <= faddr_d;
            skip_q     <= skip_d;
            halted_q   <= halted_d;
            errored_q  <= errored_d;
            err_done_q <= err_done_d;
            for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= buf_d[i];
        end
    end

endmodule

// File: doc/y86_prefetch.md
Name: y86_prefetch

Overview:
Instruction prefetch/fetch unit that sits directly upstream of the processor's decode stage. It streams 8-byte words from instruction memory into a 16-byte byte queue, finds Y86-64 instruction boundaries, and presents one fully split instruction per handshake (icode, ifun, rA, rB, valC, valP). It also accepts PC redirects from execute/writeback (jumps, call, ret), discarding stale bytes and in-flight responses.

Parameters:
BUF_BYTES, 16, byte-queue depth; must be at least 16 (two words).
RESET_PC, 64'h0, PC fetched first after reset.

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
imem_req  output  1  word-read request; held high until accepted
imem_addr  output  64  8-byte-aligned word address
imem_ready  input  1  memory accepts the request this cycle
imem_rvalid  input  1  response word valid
imem_rdata  input  64  response word, little-endian (byte 0 = bits 7:0)
imem_error  input  1  response is faulty; qualified by imem_rvalid
redirect  input  1  flush and restart at redirect_pc
redirect_pc  input  64  new PC, any alignment
ins_valid  output  1  a complete instruction is presented
ins_ready  input  1  decode consumes the instruction this cycle
PC  output  64  address of the presented instruction
icode, ifun, rA, rB  output  4 each  instruction fields; rA/rB = 4'hF when no register byte
valC  output  64  constant; 0 when none
valP  output  64  PC + instruction length
instr_valid  output  1  0 when icode > 4'hB
imem_err_out  output  1  presented slot is a memory-error marker

Behaviour:
- Reset: queue empty, head PC = RESET_PC, FSM IDLE, epoch cleared, halted/errored cleared. All outputs 0 except rA = rB = 4'hF. Reset mid-transaction drops any pending response.
- Lengths: icode 0, 1, 9 = 1 byte; 2, 6, A, B = 2; 3, 4, 5 = 10; 7, 8 = 9; icode > B = 1 byte with instr_valid = 0.
- rA/rB field mapping:
  - 2, 3, 4, 5, 6, A, B: take the register byte (rA = high nibble, rB = low nibble).
  - All others: rA = rB = 4'hF.
- valC mapping: 3, 4, 5 take bytes 2..9; 7, 8 take bytes 1..8; otherwise 0.
- ins_valid is combinational and high when count >= length of the head instruction. Header byte count is 1 for the 1-byte icodes and 2 for the rest.
- A transfer occurs on ins_valid && ins_ready: the head advances by the length, PC <= valP. While ins_ready is low, all outputs are held stable.
- Fetch FSM:
  - IDLE -> REQ when free space >= 8 and not halted/errored.
  - REQ -> WAIT on imem_ready.
  - WAIT -> IDLE on imem_rvalid; the word is appended.
  - At most one request is outstanding.
- First word after reset/redirect: imem_addr = PC & ~7, and the low PC[2:0] bytes of the response are discarded. Later words are sequential (+8).
- Fill and consume in the same cycle are both applied; count' = count + appended - consumed, never exceeding BUF_BYTES.
- Redirect (highest priority):
  - Queue flushed, ins_valid forced to 0 that cycle, PC <= redirect_pc, halted/errored cleared.
  - If in REQ, the request is dropped.
  - If in WAIT, go to DROP; the stale response is discarded on rvalid, then IDLE.
  - A new request issues no earlier than the cycle after the redirect.
- Halt: once an icode-0 instruction is transferred, no further requests issue until redirect.
- Memory error: an rvalid with imem_error appends no bytes and sets errored.
  - When the queue cannot complete the head instruction, present one slot with imem_err_out = 1, icode = 0, instr_valid = 1, valP = PC.
  - Stop fetching until redirect.

Decomposition:
- Shared package y86_pkg: icode constants (IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ), RNONE = 4'hF, fetch FSM state enum.
- One combinational sub-module, y86_ilen: takes the head bytes and returns length, field extraction, instr_valid and has_regids.

Test Plan:
- Reset; memory at 0 = 30 F3 88 77 66 55 44 33 22 11 (irmovq, straddles two words) -> ins_valid with icode 3, rA F, rB 3, valC 0x1122334455667788, PC 0, valP 10; exactly 2 word requests before it.
- ins_ready low for 6 cycles with a full queue -> outputs bit-stable, count 16, imem_req low; then consume a 1-byte nop -> the next request issues once free space >= 8.
- Redirect to 0x23 while in WAIT -> the stale response is ignored; next request to 0x20; first presented instruction has PC 0x23 built from byte 3 onward.
- Bytes 10 00 10 at 0 (nop, halt, nop) -> PCs 0 and 1 presented; after halt is transferred, no imem_req until redirect.
- Response with imem_error at word 0x8 while a 10-byte instruction starts at 0x6 -> one slot with imem_err_out = 1, PC 0x6, valP 0x6, then no requests.
- Byte 0xC0 at PC 0 -> instr_valid = 0, valP 1, rA = rB = F; next instruction at PC 1.
